// File: rtl/xor_share_arbiter_if.sv
// xor_share_arbiter_if: request, shared-XOR-unit and response signals of the arbiter
interface xor_share_arbiter_if #(
  parameter int WIDTH = 8,
  parameter int N_REQ = 4,
  parameter int TAGW  = 2
);
  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ-1:0]       req_ready;
  logic [N_REQ*WIDTH-1:0] req_a;
  logic [N_REQ*WIDTH-1:0] req_b;
  logic [WIDTH-1:0]       xor_A;
  logic [WIDTH-1:0]       xor_B;
  logic [WIDTH-1:0]       xor_ans;
  logic                   rsp_valid;
  logic [WIDTH-1:0]       rsp_ans;
  logic [TAGW-1:0]        rsp_tag;
  logic                   rsp_ready;
  logic                   busy;
  logic                   xor_err;
  modport slave (
    input  req_valid, req_a, req_b, xor_ans, rsp_ready,
    output req_ready, xor_A, xor_B, rsp_valid, rsp_ans, rsp_tag, busy, xor_err
  );
  modport master (
    output req_valid, req_a, req_b, xor_ans, rsp_ready,
    input  req_ready, xor_A, xor_B, rsp_valid, rsp_ans, rsp_tag, busy, xor_err
  );
endinterface

// File: rtl/xor_share_arbiter.sv
// xor_share_arbiter: round-robin sharing of one external XOR unit among N_REQ requesters
module xor_share_arbiter #(
  parameter int WIDTH   = 8,
  parameter int N_REQ   = 4,
  parameter int TAGW    = 2,
  parameter int LATENCY = 1,
  parameter int CHECK   = 1
) (
  input logic clk,
  input logic reset,
  xor_share_arbiter_if.slave bus
);
  localparam int PW = N_REQ > 1 ? $clog2(N_REQ) : 1;
  localparam int CW = LATENCY > 1 ? $clog2(LATENCY) : 1;
  typedef enum logic [1:0] {IDLE, OPERATE, RESP} state_t;
  state_t state, state_nx;
  logic [PW-1:0] rr, grant;
  logic [CW-1:0] cnt;
  logic [TAGW-1:0] tag;
  logic hit;
  int j;
  // rotate the search origin to rr; the lowest offset from rr with a valid wins
  always_comb begin
    grant = rr;
    hit = 1'b0;
    j = 0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      j = (int'(rr) + k) % N_REQ;
      if (bus.req_valid[j]) begin
        grant = j[PW-1:0];
        hit = 1'b1;
      end
    end
  end
  // grants only in IDLE; the FSM leaves OPERATE once the settle count runs out
  always_comb begin
    bus.req_ready = (state == IDLE && hit) ? N_REQ'(1) << grant : '0;
    state_nx = state == IDLE ? (hit ? OPERATE : IDLE) :
               state == OPERATE ? (cnt == '0 ? RESP : OPERATE) :
               (bus.rsp_ready ? IDLE : RESP);
  end
  assign bus.busy = state != IDLE;
  // operand latch on accept, capture and check at end of settle, release on response handshake
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      rr <= '0;
      cnt <= '0;
      tag <= '0;
      bus.xor_A <= '0;
      bus.xor_B <= '0;
      bus.rsp_ans <= '0;
      bus.rsp_tag <= '0;
      bus.rsp_valid <= 1'b0;
      bus.xor_err <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == IDLE && hit) begin
        bus.xor_A <= bus.req_a[grant*WIDTH +: WIDTH];
        bus.xor_B <= bus.req_b[grant*WIDTH +: WIDTH];
        tag <= TAGW'(grant);
        cnt <= CW'(LATENCY - 1);
        rr <= (int'(grant) == N_REQ - 1) ? '0 : grant + 1'b1;
      end
      if (state == OPERATE) begin
        if (cnt != '0) cnt <= cnt - 1'b1;
        else begin
          bus.rsp_ans <= bus.xor_ans;
          bus.rsp_tag <= tag;
          bus.rsp_valid <= 1'b1;
          if (CHECK != 0 && bus.xor_ans != (bus.xor_A ^ bus.xor_B)) bus.xor_err <= 1'b1;
        end
      end
      if (state == RESP && bus.rsp_ready) bus.rsp_valid <= 1'b0;
    end
  end
endmodule
